// File: rtl/stream_ctrl.sv
// stream_ctrl: byte-command decoder feeding a FIFO writer with PAUSE/RESUME watermark flow control.
// Optional error counter enabled by defining STREAM_CTRL_ERRCNT_EN.
module stream_ctrl #(
  parameter int DATA_W   = 4,
  parameter int USED_W   = 11,
  parameter int HI_WM    = 450,
  parameter int LO_WM    = 256,
  parameter int FULL_LVL = 2047
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ack,
  output logic              tx_last,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_wr,
  input  logic [USED_W-1:0] fifo_used,
  output logic [1:0]        state,
  output logic [7:0]        err_count
);
  typedef enum logic [1:0] {IDLE, WRITE, PAUSED, READ} state_t;
  localparam logic [USED_W-1:0] HI = USED_W'(HI_WM);
  localparam logic [USED_W-1:0] LO = USED_W'(LO_WM);
  localparam logic [USED_W-1:0] FULL = USED_W'(FULL_LVL);
  state_t state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_valid_q, tx_valid_d, wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0] cmd;
  logic is_data, is_cmd, free;
  assign cmd     = rx_data[7:4];
  assign is_data = rx_valid && cmd == 4'h0;
  assign is_cmd  = rx_valid && cmd != 4'h0;
  assign free    = !tx_valid_q || tx_ack;
  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q && !tx_ack;
    tx_data_d  = tx_data_q;
    wr_d       = is_data && state_q == WRITE && fifo_used < FULL;
    wdata_d    = wr_d ? rx_data[DATA_W-1:0] : wdata_q;
    if (is_cmd)
      state_d = cmd == 4'h1 ? WRITE : cmd == 4'h2 ? READ : IDLE;
    else if (state_q == READ && fifo_used == '0)
      state_d = IDLE;
    else if (free && state_q == WRITE && fifo_used >= HI) begin
      state_d    = PAUSED;
      tx_valid_d = 1'b1;
      tx_data_d  = 8'h40;
    end else if (free && state_q == PAUSED && fifo_used <= LO) begin
      state_d    = WRITE;
      tx_valid_d = 1'b1;
      tx_data_d  = 8'h50;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
    end
  end
  assign state      = state_q;
  assign tx_valid   = tx_valid_q;
  assign tx_last    = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign fifo_wr    = wr_q;
  assign fifo_wdata = wdata_q;
`ifdef STREAM_CTRL_ERRCNT_EN
  logic [7:0] err_q;
  logic err;
  // dropped DATA and illegal commands are mutually exclusive, so one increment at most
  assign err = (is_data && !wr_d) || (is_cmd && cmd > 4'h3);
  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else if (err && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end
  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif
endmodule

// File: tb/tb_stream_ctrl.sv
// tb_stream_ctrl: directed scenarios with a per-cycle behavioural model plus literal checkpoints.
module tb_stream_ctrl;
  logic clk = 0, rst = 1, rx_valid = 0, tx_ack = 0;
  logic [7:0] rx_data = 0;
  logic [10:0] fifo_used = 0;
  logic [7:0] tx_data, err_count;
  logic tx_valid, tx_last, fifo_wr;
  logic [3:0] fifo_wdata;
  logic [1:0] state;
  int n_vec = 0, n_bad = 0, cyc = 0;
  int ms = 0, merr = 0, mtxd = 0, mwd = 0;
  bit mtxv = 0, mwr = 0;
  byte hs_q[$];

  stream_ctrl dut (.clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack), .tx_last(tx_last),
    .fifo_wdata(fifo_wdata), .fifo_wr(fifo_wr), .fifo_used(fifo_used),
    .state(state), .err_count(err_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1; tick(); rx_valid = 0;
  endtask

  // Model: state as 0..3, messages and writes from the command/watermark rules
  always @(posedge clk) begin
    int c, nxt, msg;
    bit cmd_seen, err;
    cyc++;
    if (rst) begin
      ms = 0; merr = 0; mtxv = 0; mtxd = 0; mwr = 0; mwd = 0;
    end else begin
      c = int'(rx_data) / 16; nxt = ms; msg = 0; cmd_seen = 0; err = 0; mwr = 0;
      if (rx_valid) begin
        if (c == 0) begin
          if (ms == 1 && fifo_used < 2047) begin mwr = 1; mwd = int'(rx_data) % 16; end
          else err = 1;
        end else begin
          cmd_seen = 1;
          nxt = (c == 1) ? 1 : (c == 2) ? 3 : 0;
          err = c > 3;
        end
      end
      if (!cmd_seen) begin
        if (ms == 3 && fifo_used == 0) nxt = 0;
        else if (!mtxv || tx_ack) begin
          if (ms == 1 && fifo_used >= 450) begin nxt = 2; msg = 'h40; end
          else if (ms == 2 && fifo_used <= 256) begin nxt = 1; msg = 'h50; end
        end
      end
      if (msg != 0) begin mtxv = 1; mtxd = msg; end
      else if (tx_ack) mtxv = 0;
`ifdef STREAM_CTRL_ERRCNT_EN
      if (err) merr = (merr < 255) ? merr + 1 : 255;
`endif
      ms = nxt;
    end
  end

  always @(posedge clk) if (!rst && tx_valid === 1'b1 && tx_ack) hs_q.push_back(tx_data);

  always @(negedge clk) if (cyc > 0) begin
    chk("m_state", state, ms);
    chk("m_tx_valid", tx_valid, mtxv);
    chk("m_tx_last", tx_last, mtxv);
    chk("m_err", err_count, merr);
    chk("m_fifo_wr", fifo_wr, mwr);
    if (mwr) chk("m_wdata", fifo_wdata, mwd);
    if (mtxv) chk("m_tx_data", tx_data, mtxd);
  end

  initial begin
    int e;
    tick(); tick();
    chk("rst_state", state, 0); chk("rst_txv", tx_valid, 0); chk("rst_txd", tx_data, 0);
    chk("rst_wr", fifo_wr, 0); chk("rst_wdata", fifo_wdata, 0); chk("rst_err", err_count, 0);
    rst = 0;
    send(8'h10); chk("sw_state", state, 1);
    send(8'h0A); chk("wr1", fifo_wr, 1); chk("wd1", fifo_wdata, 4'hA);
    send(8'h05); chk("wr2", fifo_wr, 1); chk("wd2", fifo_wdata, 4'h5);
    tick(); chk("wr_off", fifo_wr, 0);
    tx_ack = 1;
    fifo_used = 449; tick(); chk("hi449_state", state, 1);
    fifo_used = 450; tick(); chk("hi_state", state, 2); chk("pause_v", tx_valid, 1); chk("pause_d", tx_data, 8'h40);
    tick(); chk("pause_drop", tx_valid, 0);
    for (int u = 449; u >= 257; u--) begin fifo_used = 11'(u); tick(); end
    chk("hyst_state", state, 2); chk("hyst_hs", hs_q.size(), 1);
    fifo_used = 256; tick(); chk("lo_state", state, 1); chk("resume_d", tx_data, 8'h50);
    tick(); chk("hs2", hs_q.size(), 2); chk("hs_b0", hs_q[0], 8'h40); chk("hs_b1", hs_q[1], 8'h50);
    fifo_used = 450; tick(); tick(); chk("p2_state", state, 2);
    send(8'h07); chk("drop_wr", fifo_wr, 0);
`ifdef STREAM_CTRL_ERRCNT_EN
    e = 1;
`else
    e = 0;
`endif
    chk("drop_err", err_count, e);
    fifo_used = 3; send(8'h20); chk("rd_state", state, 3); chk("cancel_no_res", tx_valid, 0);
    tick(); tick(); chk("rd_hold", state, 3);
    fifo_used = 0; tick(); chk("rd_empty", state, 0);
    send(8'h10); send(8'h9F); chk("ill_state", state, 0);
`ifdef STREAM_CTRL_ERRCNT_EN
    chk("ill_err", err_count, 2);
`else
    chk("ill_err", err_count, 0);
`endif
    for (int i = 0; i < 260; i++) send(8'h05);
`ifdef STREAM_CTRL_ERRCNT_EN
    chk("sat_err", err_count, 255);
`else
    chk("sat_err", err_count, 0);
`endif
    tx_ack = 0;
    send(8'h10); fifo_used = 450; tick();
    chk("pend_state", state, 2); chk("pend_v", tx_valid, 1); chk("pend_d", tx_data, 8'h40);
    tick(); tick(); tick(); chk("hold_v", tx_valid, 1); chk("hold_d", tx_data, 8'h40);
    rst = 1; tick(); chk("mrst_v", tx_valid, 0); chk("mrst_state", state, 0); chk("mrst_err", err_count, 0);
    rst = 0; fifo_used = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("post_v", tx_valid, 0); chk("post_state", state, 0); chk("post_hs", hs_q.size(), 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/stream_ctrl.md
STREAM_CTRL -- requirements
Module: stream_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk in (125 MHz, shared with the Ethernet block) and rst in.
REQ-002 Parameter DATA_W, default 4: width of the FIFO write data (low nibble of the payload byte, zero-extended).
REQ-003 Parameter USED_W, default 11: width of the FIFO used-words count.
REQ-004 Parameter HI_WM, default 450: used-words level that triggers PAUSE.
REQ-005 Parameter LO_WM, default 256: used-words level that triggers RESUME; LO_WM < HI_WM.
REQ-006 Parameter FULL_LVL, default 2047: used-words level at or above which no write is issued.
REQ-007 Port clk, in, 1: system clock.
REQ-008 Port rst, in, 1: synchronous reset, active high.
REQ-009 Port rx_data, in, 8: received byte; [7:4] is the command, [3:0] is the payload.
REQ-010 Port rx_valid, in, 1: rx_data is valid this cycle; one byte per asserted cycle.
REQ-011 Port tx_data, out, 8: message byte to the host.
REQ-012 Port tx_valid, out, 1: tx_data is valid; held until acknowledged.
REQ-013 Port tx_ack, in, 1: host path accepts tx_data this cycle.
REQ-014 Port tx_last, out, 1: equal to tx_valid (every message is a single byte).
REQ-015 Port fifo_wdata, out, DATA_W: FIFO write data.
REQ-016 Port fifo_wr, out, 1: FIFO write strobe, one cycle per word.
REQ-017 Port fifo_used, in, USED_W: FIFO used-words count.
REQ-018 Port state, out, 2: 0 IDLE, 1 WRITE, 2 PAUSED, 3 READ.
REQ-019 Port err_count, out, 8: error counter (see Configuration).

Function
REQ-020 Commands SHALL be decoded from the same byte they arrive in; there is no separate command register stage.
- 0x0 DATA, 0x1 START_WRITE, 0x2 START_READ, 0x3 CANCEL; 0x4-0xF are illegal.
REQ-021 START_WRITE SHALL move any state to WRITE; START_READ SHALL move any state to READ; CANCEL SHALL move any state to IDLE.
REQ-022 An illegal command SHALL move the block to IDLE and SHALL count as an error.
REQ-023 DATA in WRITE with fifo_used < FULL_LVL SHALL assert fifo_wr on the next cycle with fifo_wdata = rx_data[DATA_W-1:0]; latency is exactly 1 cycle.
REQ-024 DATA in IDLE, PAUSED or READ, or in WRITE with fifo_used >= FULL_LVL, SHALL be dropped and SHALL count as an error.
REQ-025 In WRITE with fifo_used >= HI_WM, the block SHALL move to PAUSED and queue message 0x40 (PAUSE).
REQ-026 In PAUSED with fifo_used <= LO_WM, the block SHALL move to WRITE and queue message 0x50 (RESUME).
REQ-027 In READ with fifo_used == 0, the block SHALL move to IDLE.
REQ-028 A received command SHALL take priority over a watermark or empty transition in the same cycle; a CANCEL while PAUSED sends no RESUME.
REQ-029 Watermark transitions SHALL be taken only when no message is pending (tx_valid low, or tx_ack high this cycle); otherwise they are deferred.
REQ-030 tx_data and tx_valid SHALL stay stable from assertion until the cycle in which tx_ack is high, and tx_valid SHALL drop the cycle after tx_ack.
REQ-031 Exactly one PAUSE/RESUME pair SHALL be issued per watermark excursion (hysteresis); while PAUSED, a level between LO_WM and HI_WM issues nothing.

Reset
REQ-032 While rst is high, at each clk edge: state = IDLE, fifo_wr = 0, fifo_wdata = 0, tx_valid = 0, tx_data = 0, err_count = 0.
REQ-033 A reset mid-operation SHALL discard any pending message and any pending FIFO write.

Configuration
REQ-034 Macro STREAM_CTRL_ERRCNT_EN controls the error counter.
- Defined: err_count increments by 1 per error event (REQ-022, REQ-024) and saturates at 255; a DATA byte drop and an illegal command never coincide, so there is at most 1 increment per cycle.
- Not defined: err_count is tied to 0 and no counter logic is built.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Reset, then 0x10, 0x0A, 0x05 with fifo_used = 0 -> state 1; fifo_wr pulses carry 0xA then 0x5, each 1 cycle after its byte.
- In WRITE, ramp fifo_used 449 -> 450 with tx_ack tied high -> state 2, single tx byte 0x40; ramp down to 257 -> no tx; 256 -> state 1, single tx byte 0x50.
- In PAUSED, send 0x07 -> no fifo_wr, err_count +1 (macro defined) or 0 (macro not defined).
- Send 0x20 with fifo_used = 3, then lower it to 0 -> state 3 until fifo_used = 0, then state 0 on the next cycle.
- In WRITE, send 0x9F -> state 0, err_count +1; then 260 further errors -> err_count = 255.
- Hold tx_ack low after PAUSE, then assert rst -> tx_valid = 0, state = 0 the cycle after the rst edge; no RESUME afterwards.
